// File: rtl/cordic_arbiter.sv
// ============================================================================
// Module  : cordic_arbiter
// Brief   : Round-robin, packet-atomic scheduler sharing one CORDIC pipeline
//           between C_NUM_REQ I/Q requesters, with a latency-matched ID line.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_arbiter #(
  parameter int C_NUM_REQ        = 4,
  parameter int C_TDATA_WIDTH    = 64,
  parameter int C_CORDIC_LATENCY = 17
) (
  input  logic                                    s00_axis_aclk,
  input  logic                                    s00_axis_areset,
  input  logic [C_NUM_REQ-1:0]                    s_axis_tvalid,
  input  logic [C_NUM_REQ-1:0]                    s_axis_tlast,
  input  logic [C_NUM_REQ*C_TDATA_WIDTH-1:0]      s_axis_tdata,
  output logic [C_NUM_REQ-1:0]                    s_axis_tready,
  output logic                                    cordic_s_tvalid,
  output logic                                    cordic_s_tlast,
  output logic [C_TDATA_WIDTH-1:0]                cordic_s_tdata,
  output logic                                    cordic_advance,
  input  logic                                    cordic_m_tvalid,
  input  logic                                    cordic_m_tlast,
  input  logic [C_TDATA_WIDTH-1:0]                cordic_m_tdata,
  output logic [C_NUM_REQ-1:0]                    m_axis_tvalid,
  output logic [C_NUM_REQ-1:0]                    m_axis_tlast,
  output logic [C_TDATA_WIDTH-1:0]                m_axis_tdata,
  input  logic [C_NUM_REQ-1:0]                    m_axis_tready,
  output logic [$clog2(C_CORDIC_LATENCY+1)-1:0]   in_flight,
  output logic                                    tag_err
);

  localparam int C_ID_W  = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int C_CNT_W = $clog2(C_CORDIC_LATENCY + 1);
  localparam int C_L     = C_CORDIC_LATENCY;

  typedef enum logic [1:0] {
    S_FLUSH  = 2'd0,
    S_IDLE   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_flush_cnt;
  logic [C_ID_W-1:0]    r_rr_ptr;
  logic [C_ID_W-1:0]    r_lock_id;
  logic [C_L-1:0]       r_tag_v;
  logic [C_ID_W-1:0]    r_tag_id [C_L];
  logic [C_CNT_W-1:0]   r_in_flight;
  logic                 r_tag_err;

  logic                 w_flush;
  logic                 w_tail_v;
  logic [C_ID_W-1:0]    w_tail_id;
  logic                 w_advance;
  logic [C_ID_W-1:0]    w_grant;
  logic                 w_grant_en;
  logic [C_ID_W:0]      w_sum;
  logic                 w_accept;
  logic                 w_drain;
  logic [C_ID_W-1:0]    w_next_ptr;

  assign w_flush   = (r_state == S_FLUSH);
  assign w_tail_v  = r_tag_v[C_L-1];
  assign w_tail_id = r_tag_id[C_L-1];
  assign w_advance = w_flush || !w_tail_v || m_axis_tready[w_tail_id];

  // Scan from the far end so the requester nearest rr_ptr overwrites the rest.
  always_comb begin
    w_grant    = r_rr_ptr;
    w_grant_en = 1'b0;
    w_sum      = '0;
    if (r_state == S_LOCKED) begin
      w_grant    = r_lock_id;
      w_grant_en = 1'b1;
    end else if (r_state == S_IDLE) begin
      for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
        w_sum = {1'b0, r_rr_ptr} + (C_ID_W+1)'(i);
        if (w_sum >= (C_ID_W+1)'(C_NUM_REQ))
          w_sum = w_sum - (C_ID_W+1)'(C_NUM_REQ);
        if (s_axis_tvalid[w_sum[C_ID_W-1:0]]) begin
          w_grant    = w_sum[C_ID_W-1:0];
          w_grant_en = 1'b1;
        end
      end
    end
  end

  assign w_accept   = w_grant_en && w_advance && s_axis_tvalid[w_grant];
  assign w_drain    = w_tail_v && w_advance && !w_flush;
  assign w_next_ptr = (w_grant == C_ID_W'(C_NUM_REQ - 1)) ? '0 : w_grant + C_ID_W'(1);

  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = '0;
    if (w_grant_en && w_advance)
      s_axis_tready[w_grant] = 1'b1;
    if (w_tail_v && !w_flush)
      m_axis_tvalid[w_tail_id] = 1'b1;
  end

  assign m_axis_tlast    = cordic_m_tlast ? m_axis_tvalid : '0;
  assign m_axis_tdata    = cordic_m_tdata;
  assign cordic_s_tvalid = w_accept;
  assign cordic_s_tlast  = s_axis_tlast[w_grant];
  assign cordic_s_tdata  = s_axis_tdata[w_grant*C_TDATA_WIDTH +: C_TDATA_WIDTH];
  assign cordic_advance  = w_advance;
  assign in_flight       = r_in_flight;
  assign tag_err         = r_tag_err;

  // IDs carry no meaning without their valid bit, so they need no reset.
  always_ff @(posedge s00_axis_aclk) begin
    if (w_advance) begin
      r_tag_id[0] <= w_grant;
      for (int i = 1; i < C_L; i++)
        r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= '0;
      r_rr_ptr    <= '0;
      r_lock_id   <= '0;
      r_tag_v     <= '0;
      r_in_flight <= '0;
      r_tag_err   <= 1'b0;
    end else begin
      if (w_advance)
        r_tag_v <= {r_tag_v[C_L-2:0], w_accept};

      if (w_accept && !w_drain)
        r_in_flight <= r_in_flight + C_CNT_W'(1);
      else if (!w_accept && w_drain)
        r_in_flight <= r_in_flight - C_CNT_W'(1);

      if (!w_flush && (cordic_m_tvalid != w_tail_v))
        r_tag_err <= 1'b1;

      case (r_state)
        S_FLUSH: begin
          if (r_flush_cnt == C_CNT_W'(C_L - 1)) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + C_CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            if (s_axis_tlast[w_grant]) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state   <= S_LOCKED;
              r_lock_id <= w_grant;
            end
          end
        end
        S_LOCKED: begin
          if (w_accept && s_axis_tlast[w_grant]) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= S_FLUSH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
// ============================================================================
// Module  : tb_cordic_arbiter
// Brief   : Directed self-checking bench for cordic_arbiter with a behavioural
//           17-stage CORDIC stand-in (angle field = Q, magnitude = isqrt(I^2+Q^2)).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int L = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [N*W-1:0] s_tdata;
  logic           c_s_tvalid, c_s_tlast, c_adv;
  logic [W-1:0]   c_s_tdata;
  logic           c_m_tvalid, c_m_tlast;
  logic [W-1:0]   c_m_tdata;
  logic [N-1:0]   m_tvalid, m_tlast, m_tready;
  logic [W-1:0]   m_tdata;
  logic [4:0]     in_flight;
  logic           tag_err;

  always #5 clk = ~clk;

  cordic_arbiter #(.C_NUM_REQ(N), .C_TDATA_WIDTH(W), .C_CORDIC_LATENCY(L)) u_dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tdata    (s_tdata),
    .s_axis_tready   (s_tready),
    .cordic_s_tvalid (c_s_tvalid),
    .cordic_s_tlast  (c_s_tlast),
    .cordic_s_tdata  (c_s_tdata),
    .cordic_advance  (c_adv),
    .cordic_m_tvalid (c_m_tvalid),
    .cordic_m_tlast  (c_m_tlast),
    .cordic_m_tdata  (c_m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tdata    (m_tdata),
    .m_axis_tready   (m_tready),
    .in_flight       (in_flight),
    .tag_err         (tag_err)
  );

  function automatic logic [31:0] isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r[31:0];
  endfunction

  function automatic logic [63:0] xform(input logic [63:0] d);
    longint iv, qv;
    iv = longint'(d[31:0]);
    qv = longint'(d[63:32]);
    return {d[63:32], isqrt(iv * iv + qv * qv)};
  endfunction

  // CORDIC stand-in: frozen whenever the arbiter withholds advance.
  logic [L-1:0] mv = '0;
  logic [L-1:0] ml = '0;
  logic [W-1:0] md [L] = '{default: '0};
  always @(posedge clk) begin
    if (c_adv) begin
      mv    <= {mv[L-2:0], c_s_tvalid};
      ml    <= {ml[L-2:0], c_s_tlast};
      md[0] <= xform(c_s_tdata);
      for (int i = 1; i < L; i++) md[i] <= md[i-1];
    end
  end
  assign c_m_tvalid = mv[L-1];
  assign c_m_tlast  = ml[L-1];
  assign c_m_tdata  = md[L-1];

  int           cyc = 0;
  int           acc_id[$];
  logic [W-1:0] acc_dat[$];
  int           out_id[$];
  logic [W-1:0] out_dat[$];
  int           out_last[$];
  int           out_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (s_tvalid[k] && s_tready[k]) begin
          acc_id.push_back(k);
          acc_dat.push_back(s_tdata[k*W +: W]);
        end
        if (m_tvalid[k] && m_tready[k]) begin
          out_id.push_back(k);
          out_dat.push_back(m_tdata);
          out_last.push_back(int'(m_tlast[k]));
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    acc_id.delete();  acc_dat.delete();
    out_id.delete();  out_dat.delete();
    out_last.delete(); out_cyc.delete();
  endtask

  task automatic beat(input int k, input logic [31:0] iv, input logic [31:0] qv);
    s_tdata[k*W +: W] = {qv, iv};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, lat, sc, n3, viol, t4_bi;
    logic [3:0] first_vec;
    logic done;
    int exp3 [8]  = '{3, 0, 1, 2, 3, 0, 1, 2};
    logic [3:0] tv4 [9] = '{4'b0010, 4'b1011, 4'b1011, 4'b1001, 4'b1001,
                            4'b1011, 4'b1011, 4'b1001, 4'b0001};
    int bi4 [9]   = '{0, 1, 2, 3, 3, 3, 4, 4, 4};
    int exp4 [7]  = '{1, 1, 1, 1, 1, 3, 0};
    int dat4 [7]  = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h30, 'h05};
    int last4 [7] = '{0, 0, 0, 0, 1, 1, 1};

    s_tvalid = '0; s_tlast = '1; s_tdata = '0; m_tready = '1;

    // ---------------- reset values and flush window ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_c_s_tvalid", c_s_tvalid, 0);
    chk("rst_advance", c_adv, 1);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_tag_err", tag_err, 0);
    s_tvalid = '1;
    rst = 1'b0;
    first = 0; first_vec = '0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(negedge clk);
      if (s_tready != 0) begin
        first = c;
        first_vec = s_tready;
      end
      tick();
    end
    chk("first_ready_cycle", first, 18);
    chk("first_ready_vec", first_vec, 4'b0001);
    s_tvalid = '0;
    repeat (22) tick();
    chk("t1_out_cnt", out_id.size(), 1);
    chk("t1_out_id", (out_id.size() > 0) ? out_id[0] : -1, 0);
    chk("t1_tag_err", tag_err, 0);

    // ---------------- single beat I=3, Q=4 from req 2 ----------------
    clr();
    beat(2, 32'd3, 32'd4);
    s_tvalid = 4'b0100;
    @(negedge clk);
    chk("t2_ready", s_tready, 4'b0100);
    tick();
    s_tvalid = '0;
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) chk("t2_in_flight_1", in_flight, 1);
      if (m_tvalid != 0) begin
        lat = n;
        chk("t2_m_tvalid", m_tvalid, 4'b0100);
        chk("t2_m_tdata", m_tdata, {32'd4, 32'd5});
        chk("t2_m_tlast", m_tlast, 4'b0100);
      end
      tick();
    end
    chk("t2_latency", lat, 17);
    @(negedge clk);
    chk("t2_m_tvalid_after", m_tvalid, 0);
    chk("t2_in_flight_0", in_flight, 0);

    // ---------------- all four requesters, single-beat packets ----------------
    tick();
    clr();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) beat(k, 32'(k * 16 + c), 32'd0);
      s_tvalid = '1;
      tick();
    end
    s_tvalid = '0;
    repeat (22) tick();
    chk("t3_acc_cnt", acc_id.size(), 8);
    chk("t3_out_cnt", out_id.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_acc_id", (i < acc_id.size()) ? acc_id[i] : -1, exp3[i]);
      chk("t3_out_id", (i < out_id.size()) ? out_id[i] : -1, exp3[i]);
      chk("t3_out_dat", (i < out_dat.size()) ? out_dat[i] : '1, {32'd0, 32'(exp3[i] * 16 + i)});
    end
    chk("t3_back_to_back", (out_cyc.size() == 8) ? out_cyc[7] - out_cyc[0] : -1, 7);

    // ---------------- 5-beat packet from req 1 with a 2-cycle gap ----------------
    clr();
    for (int c = 0; c < 9; c++) begin
      t4_bi = bi4[c];
      beat(0, 32'h05, 32'd0);
      beat(1, 32'(16 + t4_bi), 32'd0);
      beat(3, 32'h30, 32'd0);
      s_tlast  = {1'b1, 1'b1, (c == 6), 1'b1};
      s_tvalid = tv4[c];
      @(negedge clk);
      if (c == 3 || c == 4) chk("t4_gap_ready", s_tready, 4'b0010);
      tick();
    end
    s_tvalid = '0;
    s_tlast  = '1;
    repeat (22) tick();
    chk("t4_acc_cnt", acc_id.size(), 7);
    chk("t4_out_cnt", out_id.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk("t4_acc_id", (i < acc_id.size()) ? acc_id[i] : -1, exp4[i]);
      chk("t4_out_id", (i < out_id.size()) ? out_id[i] : -1, exp4[i]);
      chk("t4_out_dat", (i < out_dat.size()) ? out_dat[i] : '1, {32'd0, 32'(dat4[i])});
      chk("t4_out_last", (i < out_last.size()) ? out_last[i] : -1, last4[i]);
    end
    chk("t4_tag_err", tag_err, 0);

    // ---------------- downstream stall on req 0 with a full pipeline ----------------
    clr();
    beat(0, 32'd7, 32'd0);
    beat(1, 32'h21, 32'd0);
    beat(2, 32'h22, 32'd0);
    sc = 0; n3 = 0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      s_tvalid = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : (c == 2) ? 4'b0100 : 4'b1000;
      beat(3, 32'(32'h40 + n3), 32'd0);
      m_tready = (sc < 10) ? 4'b1110 : 4'b1111;
      @(negedge clk);
      if (sc < 10 && m_tvalid[0]) begin
        chk("stall_advance", c_adv, 0);
        chk("stall_ready", s_tready, 0);
        chk("stall_data", m_tdata, {32'd0, 32'd7});
        chk("stall_in_flight", in_flight, 17);
        sc++;
      end else if (sc == 10) begin
        chk("release_adv_ready", {c_adv, s_tready}, 5'b11000);
        done = 1'b1;
      end
      if (s_tvalid[3] && s_tready[3]) n3++;
      tick();
    end
    s_tvalid = '0;
    @(negedge clk);
    chk("stall_cycles", sc, 10);
    chk("swap_in_flight", in_flight, 17);
    repeat (25) tick();
    chk("t5_req3_beats", n3, 15);
    chk("t5_acc_cnt", acc_id.size(), 18);
    chk("t5_out_cnt", out_id.size(), 18);
    for (int i = 0; i < 4; i++)
      chk("t5_acc_order", (i < acc_id.size()) ? acc_id[i] : -1, i);
    for (int i = 0; i < acc_id.size(); i++) begin
      chk("t5_out_id", (i < out_id.size()) ? out_id[i] : -1, acc_id[i]);
      chk("t5_out_dat", (i < out_dat.size()) ? out_dat[i] : '1, acc_dat[i]);
    end
    chk("t5_tag_err", tag_err, 0);
    chk("t5_in_flight", in_flight, 0);

    // ---------------- reset with nine beats in flight ----------------
    clr();
    beat(0, 32'd9, 32'd0);
    s_tvalid = 4'b0001;
    repeat (9) tick();
    s_tvalid = '0;
    @(negedge clk);
    chk("t6_in_flight_9", in_flight, 9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    viol = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) chk("t6_in_flight_0", in_flight, 0);
      if (m_tvalid != 0) viol++;
      tick();
    end
    chk("t6_no_m_tvalid", viol, 0);
    repeat (5) tick();
    chk("t6_tag_err", tag_err, 0);
    chk("t6_out_cnt", out_id.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
